adc16dv160_capture_ctrl: RTL
============================

// Module: adc16dv160_capture_ctrl
// PURPOSE
//  Sequences one ADC16DV160 capture: on cr_start, streams dsize samples from the ADC input path to an AXI-Stream master.
//  Level-sync mode (cr_ls): arms and waits for a start-threshold run, then captures until a stop-threshold run or dsize.
//  Continuous mode (cr_rt): re-arms after each frame. Sits between the AXI-Lite register write block and the DMA.
// PARAMETERS
//  DATA_W  16  sample width; samples are signed two's complement
//  CNT_W   32  width of dsize / run-length counters
// PORTS
//  ACLK           in   1       clock; all logic on rising edge
//  ARESET         in   1       synchronous, active-high reset
//  cr_start       in   1       one-cycle start pulse from register block
//  cr_test        in   1       test-pattern select (see CONFIGURATION)
//  cr_rt          in   1       continuous re-arm enable
//  cr_ls          in   1       level-sync enable
//  dsize          in   CNT_W   samples per frame
//  ls_start_thr   in   DATA_W  start threshold (signed)
//  ls_stop_thr    in   DATA_W  stop threshold (signed)
//  ls_n_start     in   CNT_W   consecutive samples >= ls_start_thr to start
//  ls_n_stop      in   CNT_W   consecutive samples < ls_stop_thr to stop
//  adc_data       in   DATA_W  ADC sample
//  adc_valid      in   1       adc_data valid this cycle
//  m_axis_tdata   out  DATA_W  captured sample
//  m_axis_tvalid  out  1       sample valid
//  m_axis_tlast   out  1       last sample of frame
//  m_axis_tready  in   1       downstream ready
//  busy           out  1       state != IDLE
//  done           out  1       one-cycle pulse when frame's tlast beat is accepted
//  overflow       out  1       sticky: sample dropped due to backpressure; cleared by cr_start
// BEHAVIOUR
//  Reset: state IDLE; tdata 0, tvalid 0, tlast 0, busy 0, done 0, overflow 0, all counters 0.
//  Config inputs sampled into shadow registers on accepted cr_start; stable for whole run.
//  FSM: IDLE -cr_start & dsize!=0-> (cr_ls ? ARM : CAPTURE). ARM -start run met-> CAPTURE.
//   CAPTURE -last sample registered-> DRAIN. DRAIN -tlast beat accepted-> (shadow rt & live cr_rt ? (ls?ARM:CAPTURE) : IDLE).
//  cr_start while busy: ignored. cr_start with dsize==0: stays IDLE, done pulses next cycle.
//  Latency: adc_valid at cycle N -> m_axis_tvalid at N+1 (single output register, no FIFO).
//  Backpressure: if output register holds an unaccepted beat when adc_valid arrives in CAPTURE, sample dropped,
//   overflow set, sample not counted; stop-run counter still evaluates it.
//  ARM: run counter increments on each adc_valid with sample >= ls_start_thr, clears otherwise; ls_n_start 0 treated
//   as 1. Sample completing the run is first captured sample.
//  Level-sync stop: run counter on sample < ls_stop_thr; sample completing ls_n_stop run is tagged tlast; ls_n_stop 0
//   disables threshold stop. dsize reached first -> tlast on dsize-th sample. Both same sample -> single tlast.
//  Sample counter: CNT_W bits, compares == dsize-1, never wraps within frame.
//  Clearing cr_rt mid-frame: current frame completes, then IDLE. ARESET mid-frame: immediate return to reset values,
//   beat in flight discarded.
//  Comparisons signed, DATA_W bits; run counters saturate at all-ones.
// CONFIGURATION
//  ADC16DV160_CAPTURE_TEST_EN defined: shadow cr_test=1 replaces adc_data with a DATA_W ramp, starting 0 per frame,
//   +1 per adc_valid, wrapping; thresholds apply to ramp.
//  Undefined: cr_test ignored, adc_data always used; no ramp logic synthesized.
// STRUCTURE
//  Package adc16dv160_input_common: capture_state_t enum {IDLE, ARM, CAPTURE, DRAIN}, DATA_W/CNT_W constants.
//  Sub-module adc16dv160_run_detect: signed compare + saturating run counter, instantiated for start and stop.
// TESTING
//  Plain: dsize=8, cr_ls=0, tready=1, ramp data -> 8 beats, tlast on 8th, done 1 cycle after, busy drops.
//  Level-sync: thr_start=100, n_start=3, data 50,120,130,90,110,120,130,... -> first beat 130 (2nd run).
//  Stop: thr_stop=10, n_stop=2, dsize=100, data falls to 5,4 -> tlast on 4, frame < 100 beats.
//  Backpressure: dsize=4, tready held 0 for 3 samples -> overflow=1, 4 beats still emitted, counts exclude drops.
//  Continuous: cr_rt=1, dsize=2 -> back-to-back frames; clear cr_rt mid-frame -> frame completes, IDLE.
//  Edge: cr_start with dsize=0 -> done pulse, busy stays 0; ARESET mid-CAPTURE -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/adc16dv160_capture_ctrl_pkg.sv
// adc16dv160_input_common: shared widths and capture FSM state encoding
package adc16dv160_input_common;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 32;
   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} capture_state_t;
endpackage

// File: rtl/adc16dv160_capture_ctrl_if.sv
// adc16dv160_capture_ctrl_if: ADC sample input and AXI-Stream output bundle of the capture controller
interface adc16dv160_capture_ctrl_if;
   import adc16dv160_input_common::*;
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   modport master (input adc_data, adc_valid, m_axis_tready, output m_axis_tdata, m_axis_tvalid, m_axis_tlast);
   modport slave (output adc_data, adc_valid, m_axis_tready, input m_axis_tdata, m_axis_tvalid, m_axis_tlast);
endinterface

// File: rtl/adc16dv160_capture_ctrl_run_detect.sv
// adc16dv160_run_detect: signed threshold compare feeding a saturating run-length counter
module adc16dv160_run_detect
   import adc16dv160_input_common::*;
#(
   parameter bit BELOW = 1'b0
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] sample,
   input  logic signed [DATA_W-1:0] thr,
   output logic        [CNT_W-1:0]  run
);
   logic [CNT_W-1:0] cnt;
   logic             hit;
   assign hit = BELOW ? (sample < thr) : (sample >= thr);
   // run length including the current sample, so the caller can act on the completing sample
   always_comb run = !en ? cnt : !hit ? '0 : &cnt ? cnt : cnt + CNT_W'(1);
   // a new frame starts with an empty run
   always_ff @(posedge ACLK) cnt <= (ARESET || clr) ? '0 : run;
endmodule

// File: rtl/adc16dv160_capture_ctrl.sv
// adc16dv160_capture_ctrl: sequences ADC capture frames onto AXI-Stream; ADC16DV160_CAPTURE_TEST_EN adds a per-frame ramp source
module adc16dv160_capture_ctrl
   import adc16dv160_input_common::*;
(
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      cr_start,
   input  logic                      cr_test,
   input  logic                      cr_rt,
   input  logic                      cr_ls,
   input  logic [CNT_W-1:0]          dsize,
   input  logic [DATA_W-1:0]         ls_start_thr,
   input  logic [DATA_W-1:0]         ls_stop_thr,
   input  logic [CNT_W-1:0]          ls_n_start,
   input  logic [CNT_W-1:0]          ls_n_stop,
   adc16dv160_capture_ctrl_if.master axis,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
);
   capture_state_t           state;
   logic [CNT_W-1:0]         sh_dsize, sh_n_start, sh_n_stop, cnt, start_run, stop_run;
   logic signed [DATA_W-1:0] sh_start_thr, sh_stop_thr, sample;
   logic                     sh_rt, sh_ls, go, beat_end, rearm, frame_init, start_met, cap, full, last;
   assign go         = state == IDLE && cr_start && dsize != '0;
   assign beat_end   = axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast;
   assign rearm      = state == DRAIN && beat_end && sh_rt && cr_rt;
   assign frame_init = go || rearm;
   assign start_met  = state == ARM && axis.adc_valid && start_run >= (sh_n_start == '0 ? CNT_W'(1) : sh_n_start);
   assign cap        = axis.adc_valid && (state == CAPTURE || start_met);
   assign full       = axis.m_axis_tvalid && !axis.m_axis_tready;
   assign last       = cnt == sh_dsize - CNT_W'(1) || (sh_ls && sh_n_stop != '0 && stop_run >= sh_n_stop);
   assign busy       = state != IDLE;
`ifdef ADC16DV160_CAPTURE_TEST_EN
   logic              sh_test;
   logic [DATA_W-1:0] ramp;
   // ramp restarts every frame and advances on each ADC strobe while the frame is live
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         sh_test <= 1'b0;
         ramp    <= '0;
      end else begin
         if (go) sh_test <= cr_test;
         if (frame_init) ramp <= '0;
         else if (axis.adc_valid && (state == ARM || state == CAPTURE)) ramp <= ramp + DATA_W'(1);
      end
   end
   assign sample = sh_test ? $signed(ramp) : $signed(axis.adc_data);
`else
   logic unused;
   assign unused = cr_test;
   assign sample = $signed(axis.adc_data);
`endif
   adc16dv160_run_detect #(.BELOW(1'b0)) start_det (
      .ACLK, .ARESET, .clr(frame_init), .en(state == ARM && axis.adc_valid),
      .sample, .thr(sh_start_thr), .run(start_run)
   );
   adc16dv160_run_detect #(.BELOW(1'b1)) stop_det (
      .ACLK, .ARESET, .clr(frame_init), .en(cap),
      .sample, .thr(sh_stop_thr), .run(stop_run)
   );
   // capture sequencer: shadows config, owns the single output register and status flags
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state              <= IDLE;
         sh_dsize           <= '0;
         sh_n_start         <= '0;
         sh_n_stop          <= '0;
         sh_start_thr       <= '0;
         sh_stop_thr        <= '0;
         sh_rt              <= 1'b0;
         sh_ls              <= 1'b0;
         cnt                <= '0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tlast  <= 1'b0;
         done               <= 1'b0;
         overflow           <= 1'b0;
      end else begin
         done <= 1'b0;
         if (axis.m_axis_tvalid && axis.m_axis_tready) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tlast  <= 1'b0;
         end
         case (state)
            IDLE: if (cr_start) begin
               overflow <= 1'b0;
               done     <= dsize == '0;
               if (go) begin
                  sh_dsize     <= dsize;
                  sh_n_start   <= ls_n_start;
                  sh_n_stop    <= ls_n_stop;
                  sh_start_thr <= ls_start_thr;
                  sh_stop_thr  <= ls_stop_thr;
                  sh_rt        <= cr_rt;
                  sh_ls        <= cr_ls;
                  cnt          <= '0;
                  state        <= cr_ls ? ARM : CAPTURE;
               end
            end
            ARM, CAPTURE: if (cap) begin
               if (full) overflow <= 1'b1;
               else begin
                  axis.m_axis_tdata  <= sample;
                  axis.m_axis_tvalid <= 1'b1;
                  axis.m_axis_tlast  <= last;
                  cnt                <= cnt + CNT_W'(1);
               end
               state <= !full && last ? DRAIN : CAPTURE;
            end
            default: if (beat_end) begin
               done  <= 1'b1;
               cnt   <= '0;
               state <= rearm ? (sh_ls ? ARM : CAPTURE) : IDLE;
            end
         endcase
      end
   end
endmodule
